recip_div_ctrl: RTL and testbench
=================================

RECIP_DIV_CTRL -- requirements
Module: recip_div_ctrl

Interface
REQ-001 Parameters SHALL be: W, default 32, operand word width; F, default 16, fractional bits (QF); TIMEOUT, default 64, max cycles waiting for recip_done.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  controller can accept operands.
REQ-006 num_in  input  W  signed QF numerator.
REQ-007 den_in  input  W  signed QF denominator.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 q_out  output  W  signed QF quotient.
REQ-011 q_err  output  2  result status: 00 ok, 01 divide-by-zero, 10 denominator out of range or reciprocal invalid, 11 timeout.
REQ-012 q_sat  output  1  quotient saturated.
REQ-013 recip_start  output  1  one-cycle request pulse to the reciprocal unit.
REQ-014 recip_x  output  W  signed positive QF operand to the reciprocal unit.
REQ-015 recip_done  input  1  reciprocal unit result strobe.
REQ-016 recip_inv  input  W  unsigned QF reciprocal.
REQ-017 recip_invalid  input  1  reciprocal unit rejected its operand.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, MUL, OUT.
REQ-019 in_ready SHALL be 1 only in IDLE; a transfer is in_valid&in_ready; num_in, den_in and sign(den_in) are latched.
REQ-020 On transfer with den_in==0: load q_out=0, q_err=01, skip to OUT with no recip_start.
REQ-021 On transfer with den_in==-2^(W-1): load q_out=0, q_err=10, skip to OUT with no recip_start.
REQ-022 Otherwise: latch recip_x=|den_in| and go to REQ.
REQ-023 REQ SHALL last exactly one cycle with recip_start=1, then go to WAIT with the timeout counter cleared; recip_start SHALL be 0 in every other state.
REQ-024 WAIT: the timeout counter increments each cycle; recip_done with recip_invalid=1 -> q_err=10, q_out=0, go to OUT; recip_done with recip_invalid=0 -> latch recip_inv, go to MUL; counter reaching TIMEOUT without recip_done -> q_err=11, q_out=0, go to OUT.
REQ-025 If recip_done and timeout expiry coincide, recip_done SHALL win.
REQ-026 MUL (one cycle): p = num × recip_inv as a 2W-bit signed product, recip_inv zero-extended; arithmetic shift right by F; negate if den was negative; saturate to [-2^(W-1), 2^(W-1)-1].
REQ-027 MUL: on saturation q_sat=1, else 0; q_err=00; go to OUT.
REQ-028 OUT: out_valid=1, with q_out, q_err and q_sat held stable until out_valid&out_ready, then return to IDLE.
REQ-029 Latency from accept to out_valid SHALL be 3 + (cycles in WAIT) on the normal path and 1 on the zero/range error paths.
REQ-030 recip_done outside WAIT SHALL be ignored.

Reset
REQ-031 While rst=1 at a clock edge: state=IDLE, in_ready=0 during reset then 1 after, out_valid=0, recip_start=0, q_out=0, q_err=00, q_sat=0, recip_x=0, counter=0, latched operands=0.
REQ-032 Reset mid-operation SHALL abandon the transaction with no output and no further recip_start.

Structure
REQ-033 The state enum, the q_err code constants and default W/F SHALL live in shared package recip_pkg.
REQ-034 The saturating multiply-shift SHALL be the one sub-module fxp_mul_sat (W, F parameters; combinational).

Verification (bench uses a behavioural reciprocal model with configurable delay, W=32, F=16)
REQ-035 num=393216 (6.0), den=131072 (2.0), model returns 32768 after 10 cycles -> q_out=196608, q_err=00, q_sat=0, exactly one recip_start, recip_x=131072.
REQ-036 num=65536, den=-262144 (-4.0), model returns 16384 -> recip_x=262144, q_out=-16384 (0xFFFFC000), q_err=00.
REQ-037 den=0 -> out_valid on the next cycle, q_err=01, q_out=0, recip_start never asserted.
REQ-038 The model never asserts done -> out_valid after 64 WAIT cycles, q_err=11, q_out=0; a later stray recip_done is ignored.
REQ-039 num=0x7FFF0000, model returns 0x00040000 (4.0) -> q_out=0x7FFFFFFF, q_sat=1; the same with den negative -> q_out=0x80000000, q_sat=1.
REQ-040 Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; assert rst during WAIT -> IDLE, out_valid=0, no output.

Source files
------------

// File: rtl/recip_pkg.sv
`default_nettype none
// ============================================================================
// recip_pkg : shared states, status codes and default widths for recip_div_ctrl
// Rev 1.0
// ============================================================================
package recip_pkg;

   localparam int DEFAULT_W = 32;
   localparam int DEFAULT_F = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_MUL  = 3'd3,
      ST_OUT  = 3'd4
   } state_t;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_DIV0    = 2'b01;
   localparam logic [1:0] ERR_RANGE   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/recip_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// recip_div_ctrl_if : operand/result handshakes and reciprocal-unit link
// Rev 1.0
// ============================================================================
interface recip_div_ctrl_if
   import recip_pkg::*;
#(
   parameter int W = DEFAULT_W
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] num_in;
   logic [W-1:0] den_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] q_out;
   logic [1:0]   q_err;
   logic         q_sat;
   logic         recip_start;
   logic [W-1:0] recip_x;
   logic         recip_done;
   logic [W-1:0] recip_inv;
   logic         recip_invalid;

   // master is the divider controller, slave is its environment
   modport master (
      input  in_valid, num_in, den_in, out_ready, recip_done, recip_inv, recip_invalid,
      output in_ready, out_valid, q_out, q_err, q_sat, recip_start, recip_x
   );

   modport slave (
      output in_valid, num_in, den_in, out_ready, recip_done, recip_inv, recip_invalid,
      input  in_ready, out_valid, q_out, q_err, q_sat, recip_start, recip_x
   );

endinterface
`default_nettype wire

// File: rtl/fxp_mul_sat.sv
`default_nettype none
// ============================================================================
// fxp_mul_sat : signed QF x unsigned QF multiply, shift by F, optional negate,
//               saturate to W bits. Purely combinational. Rev 1.0
// ============================================================================
module fxp_mul_sat #(
   parameter int W = 32,
   parameter int F = 16
) (
   input  wire logic signed [W-1:0] a,
   input  wire logic        [W-1:0] b,
   input  wire logic                neg,
   output      logic        [W-1:0] y,
   output      logic                sat
);

   localparam logic signed [2*W-1:0] MAX_V = {{(W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W-1:0] MIN_V = {{(W+1){1'b1}}, {(W-1){1'b0}}};

   logic signed [2*W-1:0] w_prod;
   logic signed [2*W-1:0] w_shift;
   logic signed [2*W-1:0] w_val;

   always_comb begin
      w_prod  = $signed({{W{a[W-1]}}, a}) * $signed({{W{1'b0}}, b});
      w_shift = w_prod >>> F;
      w_val   = neg ? -w_shift : w_shift;
      y       = w_val[W-1:0];
      sat     = 1'b0;
      if (w_val > MAX_V) begin
         y   = MAX_V[W-1:0];
         sat = 1'b1;
      end else if (w_val < MIN_V) begin
         y   = MIN_V[W-1:0];
         sat = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/recip_div_ctrl.sv
`default_nettype none
// ============================================================================
// recip_div_ctrl : divides num/den by requesting 1/|den| from an external
//                  reciprocal unit and multiplying. Rev 1.0
// ============================================================================
module recip_div_ctrl
   import recip_pkg::*;
#(
   parameter int W       = DEFAULT_W,
   parameter int F       = DEFAULT_F,
   parameter int TIMEOUT = 64
) (
   input wire logic         clk,
   input wire logic         rst,
   recip_div_ctrl_if.master bus
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] DEN_MIN = {1'b1, {(W-1){1'b0}}};

   state_t        state_q, state_d;
   logic [W-1:0]  num_q, num_d;
   logic          neg_q, neg_d;
   logic [W-1:0]  recip_x_q, recip_x_d;
   logic [W-1:0]  inv_q, inv_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  q_out_q, q_out_d;
   logic [1:0]    q_err_q, q_err_d;
   logic          q_sat_q, q_sat_d;

   logic [W-1:0]  mul_y;
   logic          mul_sat;

   fxp_mul_sat #(.W(W), .F(F)) u_mul (
      .a   ($signed(num_q)),
      .b   (inv_q),
      .neg (neg_q),
      .y   (mul_y),
      .sat (mul_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         num_q     <= '0;
         neg_q     <= 1'b0;
         recip_x_q <= '0;
         inv_q     <= '0;
         cnt_q     <= '0;
         q_out_q   <= '0;
         q_err_q   <= ERR_OK;
         q_sat_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         neg_q     <= neg_d;
         recip_x_q <= recip_x_d;
         inv_q     <= inv_d;
         cnt_q     <= cnt_d;
         q_out_q   <= q_out_d;
         q_err_q   <= q_err_d;
         q_sat_q   <= q_sat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      neg_d     = neg_q;
      recip_x_d = recip_x_q;
      inv_d     = inv_q;
      cnt_d     = cnt_q;
      q_out_d   = q_out_q;
      q_err_d   = q_err_q;
      q_sat_d   = q_sat_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               num_d   = bus.num_in;
               neg_d   = bus.den_in[W-1];
               q_sat_d = 1'b0;
               if (bus.den_in == '0) begin
                  q_out_d = '0;
                  q_err_d = ERR_DIV0;
                  state_d = ST_OUT;
               end else if (bus.den_in == DEN_MIN) begin
                  // |den| is not representable as a positive operand
                  q_out_d = '0;
                  q_err_d = ERR_RANGE;
                  state_d = ST_OUT;
               end else begin
                  recip_x_d = bus.den_in[W-1] ? (~bus.den_in + 1'b1) : bus.den_in;
                  state_d   = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // done takes priority over a coincident timeout
            if (bus.recip_done) begin
               if (bus.recip_invalid) begin
                  q_out_d = '0;
                  q_err_d = ERR_RANGE;
                  state_d = ST_OUT;
               end else begin
                  inv_d   = bus.recip_inv;
                  state_d = ST_MUL;
               end
            end else if (cnt_q + 1'b1 == CW'(TIMEOUT)) begin
               q_out_d = '0;
               q_err_d = ERR_TIMEOUT;
               state_d = ST_OUT;
            end
         end
         ST_MUL: begin
            q_out_d = mul_y;
            q_sat_d = mul_sat;
            q_err_d = ERR_OK;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.in_ready    = (state_q == ST_IDLE) && !rst;
   assign bus.out_valid   = (state_q == ST_OUT);
   assign bus.recip_start = (state_q == ST_REQ);
   assign bus.recip_x     = recip_x_q;
   assign bus.q_out       = q_out_q;
   assign bus.q_err       = q_err_q;
   assign bus.q_sat       = q_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_recip_div_ctrl.sv
`default_nettype none
// ============================================================================
// tb_recip_div_ctrl : directed vector table plus reset/stray-strobe sequences
// Rev 1.0
// ============================================================================
module tb_recip_div_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   recip_div_ctrl_if #(.W(32)) bus ();

   recip_div_ctrl #(.W(32), .F(16), .TIMEOUT(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] num;
      logic [31:0] den;
      int          dly;
      logic [31:0] inv;
      bit          inval;
      bit          never;
      int          hold;
      logic [31:0] eq;
      logic [1:0]  eerr;
      bit          esat;
      logic [31:0] ex;
      int          elat;
      int          estart;
   } vec_t;

   vec_t vecs [11];

   int n_vec = 0;
   int n_err = 0;
   int start_cnt = 0;

   int          m_dly   = 1;
   logic [31:0] m_inv   = '0;
   bit          m_inval = 1'b0;
   bit          m_never = 1'b0;
   logic        m_done  = 1'b0;
   logic        s_done  = 1'b0;

   assign bus.recip_done = m_done | s_done;

   // reciprocal model: strobe lands in the m_dly-th WAIT cycle
   initial begin
      bus.recip_inv     = '0;
      bus.recip_invalid = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.recip_start && !m_never) begin
            repeat (m_dly) @(negedge clk);
            m_done            = 1'b1;
            bus.recip_inv     = m_inv;
            bus.recip_invalid = m_inval;
            @(negedge clk);
            m_done = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (bus.recip_start) start_cnt++;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int g;
      int lat;
      logic [31:0] q_hold;
      m_dly     = v.dly;
      m_inv     = v.inv;
      m_inval   = v.inval;
      m_never   = v.never;
      start_cnt = 0;
      g = 0;
      while (!bus.in_ready && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      chk($sformatf("v%0d in_ready", idx), 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.num_in   = v.num;
      bus.den_in   = v.den;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.elat));
      chk($sformatf("v%0d q_out", idx), 64'(bus.q_out), 64'(v.eq));
      chk($sformatf("v%0d q_err", idx), 64'(bus.q_err), 64'(v.eerr));
      chk($sformatf("v%0d q_sat", idx), 64'(bus.q_sat), 64'(v.esat));
      chk($sformatf("v%0d starts", idx), 64'(start_cnt), 64'(v.estart));
      if (v.estart != 0)
         chk($sformatf("v%0d recip_x", idx), 64'(bus.recip_x), 64'(v.ex));
      q_hold = v.eq;
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk); #1;
         chk($sformatf("v%0d hold%0d", idx, h),
             {31'd0, bus.out_valid, bus.in_ready, bus.q_out},
             {31'd0, 1'b1, 1'b0, q_hold});
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk($sformatf("v%0d release", idx), {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
   endtask

   initial begin
      //         num           den           dly inv           iv nv hold  q             err   sat   x             lat st
      vecs[0]  = '{32'd393216,  32'd131072,   10, 32'd32768,    0, 0, 5,  32'd196608,   2'b00, 0, 32'd131072,   13, 1};
      vecs[1]  = '{32'd65536,   32'hFFFC0000, 3,  32'd16384,    0, 0, 0,  32'hFFFFC000, 2'b00, 0, 32'd262144,   6,  1};
      vecs[2]  = '{32'd65536,   32'd0,        1,  32'd0,        0, 0, 0,  32'd0,        2'b01, 0, 32'd0,        1,  0};
      vecs[3]  = '{32'd65536,   32'h80000000, 1,  32'd0,        0, 0, 0,  32'd0,        2'b10, 0, 32'd0,        1,  0};
      vecs[4]  = '{32'h7FFF0000, 32'h00004000, 2, 32'h00040000, 0, 0, 0,  32'h7FFFFFFF, 2'b00, 1, 32'h00004000, 5,  1};
      vecs[5]  = '{32'h7FFF0000, 32'hFFFFC000, 2, 32'h00040000, 0, 0, 0,  32'h80000000, 2'b00, 1, 32'h00004000, 5,  1};
      vecs[6]  = '{32'd65536,   32'd65536,    4,  32'd0,        1, 0, 0,  32'd0,        2'b10, 0, 32'd65536,    6,  1};
      vecs[7]  = '{32'hFFFD0000, 32'd131072,  1,  32'd32768,    0, 0, 0,  32'hFFFE8000, 2'b00, 0, 32'd131072,   4,  1};
      vecs[8]  = '{32'hFFFFFFFF, 32'd196608,  2,  32'd21845,    0, 0, 0,  32'hFFFFFFFF, 2'b00, 0, 32'd196608,   5,  1};
      vecs[9]  = '{32'd65536,   32'd65536,    64, 32'd65536,    0, 0, 0,  32'd65536,    2'b00, 0, 32'd65536,    67, 1};
      vecs[10] = '{32'd65536,   32'd65536,    1,  32'd0,        0, 1, 0,  32'd0,        2'b11, 0, 32'd65536,    66, 1};

      bus.in_valid  = 1'b0;
      bus.num_in    = '0;
      bus.den_in    = '0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", 64'(bus.in_ready), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst outputs",
          {bus.in_ready, bus.out_valid, bus.recip_start, bus.q_sat, bus.q_err, bus.q_out, bus.recip_x},
          {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0});

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // a strobe arriving in IDLE after the timeout must be ignored
      start_cnt = 0;
      s_done = 1'b1;
      @(posedge clk); #1;
      s_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("stray c%0d", k), {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
      end
      chk("stray starts", 64'(start_cnt), 64'd0);

      // reset while waiting on the reciprocal unit
      m_never = 1'b1;
      start_cnt = 0;
      bus.in_valid = 1'b1;
      bus.num_in   = 32'd65536;
      bus.den_in   = 32'd65536;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst during", {62'd0, bus.in_ready, bus.out_valid}, 64'd0);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("midrst c%0d", k), {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
      end
      chk("midrst starts", 64'(start_cnt), 64'd1);
      chk("midrst regs", {bus.q_err, bus.q_sat, bus.q_out, bus.recip_x}, 67'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
